// File: rtl/dff_stage.sv
// Clocked storage cell with true and complemented outputs, parameterizable
// width and depth; covers plain/inverted flip-flops and synchronizer chains.
module dff_stage #(
  parameter int               WIDTH  = 1,
  parameter int               STAGES = 1,
  parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qdash
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("dff_stage: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
      $error("dff_stage: STAGES must be >= 1");
    end
  endgenerate

  // Declaration value gives a defined INIT state from power-up, before any reset.
  logic [STAGES-1:0][WIDTH-1:0] r_stage = {STAGES{INIT}};
  logic [WIDTH-1:0]             w_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stage <= {STAGES{INIT}};
    end else if (EN) begin
      r_stage[0] <= D;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // Both outputs come from the same register so they always switch together.
  assign w_last = r_stage[STAGES-1];
  assign Q      = w_last;
  assign Qdash  = ~w_last;

endmodule

// File: tb/tb_dff_stage.sv
// Scoreboard bench for dff_stage: four configurations, expectations queued by
// the stimulus process and compared by an independent monitor.
module tb_dff_stage;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // u0: default 1-bit, 1 stage
  logic       rst0 = 1'b0, en0 = 1'b1, d0 = 1'b0, q0, qd0;
  // u3: 1-bit, 3 stages
  logic       rst3 = 1'b0, en3 = 1'b1, d3 = 1'b0, q3, qd3;
  // u8: 8-bit, 2 stages, INIT=A5
  logic       rst8 = 1'b0, en8 = 1'b0;
  logic [7:0] d8 = 8'h00, q8, qd8;
  // u2: 1-bit, 2 stages
  logic       rst2 = 1'b0, en2 = 1'b1, d2 = 1'b0, q2, qd2;

  dff_stage u0 (.CLK(CLK), .RST(rst0), .EN(en0), .D(d0), .Q(q0), .Qdash(qd0));
  dff_stage #(.STAGES(3)) u3 (.CLK(CLK), .RST(rst3), .EN(en3), .D(d3), .Q(q3), .Qdash(qd3));
  dff_stage #(.WIDTH(8), .STAGES(2), .INIT(8'hA5)) u8 (.CLK(CLK), .RST(rst8), .EN(en8), .D(d8), .Q(q8), .Qdash(qd8));
  dff_stage #(.STAGES(2)) u2 (.CLK(CLK), .RST(rst2), .EN(en2), .D(d2), .Q(q2), .Qdash(qd2));

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] q;
    logic [7:0] qd;
  } exp_t;

  exp_t exp_q[$];
  event push_ev;
  int   n_checks = 0;
  int   n_errs   = 0;

  // Monitor: pops every queued expectation and compares against the live outputs.
  initial begin : monitor
    exp_t       e;
    logic [7:0] aq, aqd;
    forever begin
      @(push_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.dut)
          0:       begin aq = {7'b0, q0}; aqd = {7'b0, qd0}; end
          3:       begin aq = {7'b0, q3}; aqd = {7'b0, qd3}; end
          8:       begin aq = q8;         aqd = qd8;         end
          default: begin aq = {7'b0, q2}; aqd = {7'b0, qd2}; end
        endcase
        n_checks++;
        if (aq !== e.q || aqd !== e.qd) begin
          n_errs++;
          $display("FAIL %s: got Q=%h Qdash=%h, expected Q=%h Qdash=%h",
                   e.name, aq, aqd, e.q, e.qd);
        end
      end
    end
  end

  task automatic expect1(input string name, input int dut, input logic q);
    exp_t e;
    e.name = name; e.dut = dut; e.q = {7'b0, q}; e.qd = {7'b0, ~q};
    exp_q.push_back(e);
    -> push_ev;
    #1;
  endtask

  task automatic expect8(input string name, input logic [7:0] q, input logic [7:0] qd);
    exp_t e;
    e.name = name; e.dut = 8; e.q = q; e.qd = qd;
    exp_q.push_back(e);
    -> push_ev;
    #1;
  endtask

  // Advance past the next rising edge; stimulus and sampling stay 2 units clear of it.
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=20000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1;
    expect1("u0_powerup", 0, 1'b0);
    expect8("u8_powerup", 8'hA5, 8'h5A);
    expect1("u3_powerup", 3, 1'b0);

    // Plain flip-flop behaviour
    d0 = 1'b1; step(); expect1("u0_d1", 0, 1'b1);
    d0 = 1'b0; step(); expect1("u0_d0", 0, 1'b0);

    // Async reset with no clock edge
    d0 = 1'b1; step(); expect1("u0_set", 0, 1'b1);
    rst0 = 1'b1; #1; expect1("u0_async_rst", 0, 1'b0);
    step(); expect1("u0_rst_hold1", 0, 1'b0);
    step(); expect1("u0_rst_hold2", 0, 1'b0);
    rst0 = 1'b0; #1; expect1("u0_rel_noedge", 0, 1'b0);
    step(); expect1("u0_after_rel", 0, 1'b1);

    // Enable hold
    d0 = 1'b0; step(); expect1("u0_clear", 0, 1'b0);
    d0 = 1'b1; en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect1($sformatf("u0_en_hold%0d", i), 0, 1'b0);
    end
    en0 = 1'b1; step(); expect1("u0_en_resume", 0, 1'b1);

    // Three-stage latency
    d3 = 1'b1; step(); expect1("u3_e1", 3, 1'b0);
    d3 = 1'b0; step(); expect1("u3_e2", 3, 1'b0);
    step(); expect1("u3_e3", 3, 1'b1);
    step(); expect1("u3_e4", 3, 1'b0);

    // Same pulse with one stalled edge
    d3 = 1'b1; step(); expect1("u3g_e1", 3, 1'b0);
    d3 = 1'b0; en3 = 1'b0; step(); expect1("u3g_stall", 3, 1'b0);
    en3 = 1'b1; step(); expect1("u3g_e2", 3, 1'b0);
    step(); expect1("u3g_e3", 3, 1'b1);
    step(); expect1("u3g_e4", 3, 1'b0);

    // Wide with non-zero INIT
    d8 = 8'hFF; en8 = 1'b1; step(); expect8("u8_pre1", 8'hA5, 8'h5A);
    step(); expect8("u8_pre2", 8'hFF, 8'h00);
    rst8 = 1'b1; #1; expect8("u8_rst", 8'hA5, 8'h5A);
    step(); rst8 = 1'b0; d8 = 8'h3C;
    step(); expect8("u8_e1", 8'hA5, 8'h5A);
    step(); expect8("u8_e2", 8'h3C, 8'hC3);

    // Reset discards in-flight data
    d2 = 1'b1; step(); expect1("u2_e1", 2, 1'b0);
    rst2 = 1'b1; #1; expect1("u2_rst", 2, 1'b0);
    step(); expect1("u2_rst_e2", 2, 1'b0);
    step(); expect1("u2_rst_e3", 2, 1'b0);
    rst2 = 1'b0; d2 = 1'b0;
    step(); expect1("u2_flush", 2, 1'b0);
    d2 = 1'b1; step(); expect1("u2_new_e1", 2, 1'b0);
    step(); expect1("u2_new_e2", 2, 1'b1);

    #1;
    if (exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
